// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester arbiter/sequencer for a single-ported
// unified instruction/data memory with fixed latency MEM_LAT.
// Fetch (IF) and load/store (MEM) requests are granted round-robin on ties,
// the granted request is held on the m_* bus for MEM_LAT cycles, and the
// result is returned with a one-cycle ack pulse.
// Optional build macro: MEMARB_PERF_EN adds saturating per-port stall-cycle
// counters (if_wait_cnt, mem_wait_cnt).
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 3
) (
  input  logic        Clk,
  input  logic        R,
`ifdef MEMARB_PERF_EN
  output logic [15:0] if_wait_cnt,
  output logic [15:0] mem_wait_cnt,
`endif
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        mem_req,
  input  logic        mem_rw,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [1:0]  mem_size,
  input  logic        mem_se,
  output logic        mem_ack,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        m_en,
  output logic        m_rw,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [1:0]  m_size,
  output logic        m_se,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
  localparam logic [1:0]       SIZE_WORD = 2'b10;
  localparam logic             GRANT_IF  = 1'b0;
  localparam logic             GRANT_MEM = 1'b1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;

  // A requester is not eligible in its own ack cycle, so a held request
  // cannot be re-granted before the requester has seen the ack.
  logic if_elig, mem_elig, grant_if, grant_mem;

  assign if_elig   = if_req  & ~if_ack;
  assign mem_elig  = mem_req & ~mem_ack;
  assign grant_mem = mem_elig & (~if_elig  | (last_grant == GRANT_IF));
  assign grant_if  = if_elig  & (~mem_elig | (last_grant == GRANT_MEM));

  assign if_stall  = if_req  & ~if_ack;
  assign mem_stall = mem_req & ~mem_ack;

  // Arbitration FSM with registered memory bus, acks and read-data returns.
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      // NOTE: reset also clears the datapath registers (m_*, rdata) so a
      // mid-access reset leaves nothing stale on the memory bus.
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= GRANT_IF;
      m_en       <= 1'b0;
      m_rw       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_size     <= '0;
      m_se       <= 1'b0;
      if_ack     <= 1'b0;
      mem_ack    <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_mem) begin
            m_en       <= 1'b1;
            m_rw       <= mem_rw;
            m_addr     <= mem_addr;
            m_wdata    <= mem_wdata;
            m_size     <= mem_size;
            m_se       <= mem_se;
            cnt        <= CNT_INIT;
            last_grant <= GRANT_MEM;
            state      <= BUSY_MEM;
          end else if (grant_if) begin
            m_en       <= 1'b1;
            m_rw       <= 1'b0;
            m_addr     <= if_addr;
            m_size     <= SIZE_WORD;
            m_se       <= 1'b0;
            cnt        <= CNT_INIT;
            last_grant <= GRANT_IF;
            state      <= BUSY_IF;
          end
        end
        BUSY_IF: begin
          if (cnt == '0) begin
            if_rdata <= m_rdata;
            if_ack   <= 1'b1;
            m_en     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        BUSY_MEM: begin
          if (cnt == '0) begin
            if (!m_rw) mem_rdata <= m_rdata;
            mem_ack <= 1'b1;
            m_en    <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          m_en  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEMARB_PERF_EN
  // Saturating counts of cycles each requester spends stalled.
  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      if_wait_cnt  <= '0;
      mem_wait_cnt <= '0;
    end else begin
      if (if_stall  && (if_wait_cnt  != 16'hFFFF)) if_wait_cnt  <= if_wait_cnt  + 16'd1;
      if (mem_stall && (mem_wait_cnt != 16'hFFFF)) mem_wait_cnt <= mem_wait_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (MEM_LAT=2). Memory model returns
// 0x8A000001 for address 0x10 and the bitwise inverse of the address otherwise.
module tb_mem_port_arbiter;

  logic        Clk = 1'b0;
  logic        R   = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        mem_req = 1'b0;
  logic        mem_rw = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [1:0]  mem_size = 2'b10;
  logic        mem_se = 1'b0;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        m_en;
  logic        m_rw;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [1:0]  m_size;
  logic        m_se;
  logic [31:0] m_rdata;
`ifdef MEMARB_PERF_EN
  logic [15:0] if_wait_cnt;
  logic [15:0] mem_wait_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  assign m_rdata = (m_addr == 32'h10) ? 32'h8A00_0001 : ~m_addr;

  mem_port_arbiter #(.MEM_LAT(2), .CNT_W(3)) dut (
    .Clk(Clk), .R(R),
`ifdef MEMARB_PERF_EN
    .if_wait_cnt(if_wait_cnt), .mem_wait_cnt(mem_wait_cnt),
`endif
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .if_stall(if_stall), .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_se(mem_se), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .m_en(m_en), .m_rw(m_rw),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size), .m_se(m_se),
    .m_rdata(m_rdata)
  );

  // Advance one clock; return 1 ns after the edge so outputs have settled.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    R = 1'b0; if_req = 1'b1; mem_req = 1'b1;
    step(); step();
    n_checks++; if (m_en !== 1'b0) begin n_fail++; $display("FAIL reset_m_en: got %0b exp 0", m_en); end
    n_checks++; if (if_ack !== 1'b0 || mem_ack !== 1'b0) begin n_fail++; $display("FAIL reset_acks: got if=%0b mem=%0b exp 0/0", if_ack, mem_ack); end
    n_checks++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got if=%h mem=%h exp 0/0", if_rdata, mem_rdata); end
    n_checks++; if (if_stall !== 1'b1 || mem_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stalls: got if=%0b mem=%0b exp 1/1", if_stall, mem_stall); end
    if_req = 1'b0; mem_req = 1'b0;
    step();
    R = 1'b1;
    step();
    n_checks++; if (m_en !== 1'b0) begin n_fail++; $display("FAIL reset_idle_m_en: got %0b exp 0", m_en); end
  endtask

  task automatic test_lone_fetch();
    if_req = 1'b1; if_addr = 32'h10;
    step(); // grant edge t0
    n_checks++; if (m_en !== 1'b1 || m_addr !== 32'h10) begin n_fail++; $display("FAIL fetch_t0_bus: got en=%0b addr=%h exp 1/00000010", m_en, m_addr); end
    n_checks++; if (m_size !== 2'b10 || m_rw !== 1'b0 || m_se !== 1'b0) begin n_fail++; $display("FAIL fetch_t0_ctl: got size=%b rw=%0b se=%0b exp 10/0/0", m_size, m_rw, m_se); end
    n_checks++; if (if_ack !== 1'b0 || if_stall !== 1'b1) begin n_fail++; $display("FAIL fetch_t0_hs: got ack=%0b stall=%0b exp 0/1", if_ack, if_stall); end
    step(); // t0+1
    n_checks++; if (m_en !== 1'b1 || m_addr !== 32'h10 || if_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_t1: got en=%0b addr=%h ack=%0b exp 1/00000010/0", m_en, m_addr, if_ack); end
    step(); // t0+2 completion
    n_checks++; if (if_ack !== 1'b1) begin n_fail++; $display("FAIL fetch_ack: got %0b exp 1", if_ack); end
    n_checks++; if (if_rdata !== 32'h8A00_0001) begin n_fail++; $display("FAIL fetch_rdata: got %h exp 8a000001", if_rdata); end
    n_checks++; if (if_stall !== 1'b0 || m_en !== 1'b0) begin n_fail++; $display("FAIL fetch_ack_cycle: got stall=%0b en=%0b exp 0/0", if_stall, m_en); end
    step(); // t0+3: request still held during ack cycle must not be re-granted
    n_checks++; if (m_en !== 1'b0 || if_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_no_regrant: got en=%0b ack=%0b exp 0/0", m_en, if_ack); end
    n_checks++; if (if_rdata !== 32'h8A00_0001) begin n_fail++; $display("FAIL fetch_rdata_hold: got %h exp 8a000001", if_rdata); end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_tie_after_reset();
    R = 1'b0;
    if_req = 1'b1; if_addr = 32'h14;
    mem_req = 1'b1; mem_rw = 1'b0; mem_addr = 32'h40; mem_size = 2'b10; mem_se = 1'b0;
    step(); step();
    R = 1'b1;
    step(); // t0
    n_checks++; if (m_en !== 1'b1 || m_addr !== 32'h40) begin n_fail++; $display("FAIL tie_first_grant: got en=%0b addr=%h exp 1/00000040", m_en, m_addr); end
    step(); // t0+1
    n_checks++; if (if_stall !== 1'b1 || mem_stall !== 1'b1) begin n_fail++; $display("FAIL tie_t1_stall: got if=%0b mem=%0b exp 1/1", if_stall, mem_stall); end
    step(); // t0+2
    n_checks++; if (mem_ack !== 1'b1 || mem_rdata !== 32'hFFFF_FFBF) begin n_fail++; $display("FAIL tie_mem_ack: got ack=%0b rdata=%h exp 1/ffffffbf", mem_ack, mem_rdata); end
    n_checks++; if (if_stall !== 1'b1 || if_ack !== 1'b0) begin n_fail++; $display("FAIL tie_t2_if: got stall=%0b ack=%0b exp 1/0", if_stall, if_ack); end
    mem_req = 1'b0;
    step(); // t0+3
    n_checks++; if (m_en !== 1'b1 || m_addr !== 32'h14 || m_size !== 2'b10) begin n_fail++; $display("FAIL tie_if_grant: got en=%0b addr=%h size=%b exp 1/00000014/10", m_en, m_addr, m_size); end
    n_checks++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL tie_t3_stall: got %0b exp 1", if_stall); end
    step(); // t0+4
    n_checks++; if (if_stall !== 1'b1 || if_ack !== 1'b0) begin n_fail++; $display("FAIL tie_t4: got stall=%0b ack=%0b exp 1/0", if_stall, if_ack); end
    step(); // t0+5
    n_checks++; if (if_ack !== 1'b1 || if_rdata !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL tie_if_ack: got ack=%0b rdata=%h exp 1/ffffffeb", if_ack, if_rdata); end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_contention();
    int exp_cyc [4] = '{2, 5, 8, 11};
    bit exp_mem [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int n_acks = 0;
    if_addr = 32'h14; mem_addr = 32'h40; mem_rw = 1'b0;
    if_req = 1'b1; mem_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 11) begin if_req = 1'b0; mem_req = 1'b0; end
      if (if_ack === 1'b1 || mem_ack === 1'b1) begin
        if (n_acks < 4) begin
          n_checks++;
          if (k !== exp_cyc[n_acks] || mem_ack !== exp_mem[n_acks] || (if_ack & mem_ack) !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_ack%0d: got cycle=%0d mem_ack=%0b if_ack=%0b exp cycle=%0d mem_ack=%0b", n_acks, k, mem_ack, if_ack, exp_cyc[n_acks], exp_mem[n_acks]);
          end
        end
        n_acks++;
      end
    end
    n_checks++; if (n_acks !== 4) begin n_fail++; $display("FAIL contention_count: got %0d acks exp 4", n_acks); end
    step();
  endtask

  task automatic test_store();
    mem_req = 1'b1; mem_rw = 1'b1; mem_addr = 32'h20; mem_wdata = 32'hDEAD_BEEF; mem_size = 2'b00;
    step(); // t0
    n_checks++; if (m_en !== 1'b1 || m_rw !== 1'b1 || m_wdata !== 32'hDEAD_BEEF || m_size !== 2'b00 || m_addr !== 32'h20) begin n_fail++; $display("FAIL store_t0_bus: got en=%0b rw=%0b wdata=%h size=%b addr=%h exp 1/1/deadbeef/00/00000020", m_en, m_rw, m_wdata, m_size, m_addr); end
    step(); // t0+1
    n_checks++; if (m_rw !== 1'b1 || m_wdata !== 32'hDEAD_BEEF || m_size !== 2'b00 || mem_ack !== 1'b0) begin n_fail++; $display("FAIL store_t1_bus: got rw=%0b wdata=%h size=%b ack=%0b exp 1/deadbeef/00/0", m_rw, m_wdata, m_size, mem_ack); end
    step(); // t0+2
    n_checks++; if (mem_ack !== 1'b1) begin n_fail++; $display("FAIL store_ack: got %0b exp 1", mem_ack); end
    n_checks++; if (mem_rdata !== 32'hFFFF_FFBF) begin n_fail++; $display("FAIL store_rdata_hold: got %h exp ffffffbf", mem_rdata); end
    mem_req = 1'b0; mem_rw = 1'b0; mem_size = 2'b10;
    step();
  endtask

  task automatic test_reset_mid_access();
    bit saw_ack = 1'b0;
    if_req = 1'b1; if_addr = 32'h18;
    step(); // grant edge
    n_checks++; if (m_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_grant: got %0b exp 1", m_en); end
    #2 R = 1'b0;
    #1;
    n_checks++; if (m_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_m_en_async: got %0b exp 0", m_en); end
    if_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 1) R = 1'b1;
      if (if_ack === 1'b1) saw_ack = 1'b1;
    end
    n_checks++; if (saw_ack !== 1'b0 || m_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_ack: got saw_ack=%0b en=%0b exp 0/0", saw_ack, m_en); end
    // Idle state: a fresh request is granted on the very next edge.
    if_req = 1'b1; if_addr = 32'h10;
    step();
    n_checks++; if (m_en !== 1'b1 || m_addr !== 32'h10) begin n_fail++; $display("FAIL rstmid_idle_grant: got en=%0b addr=%h exp 1/00000010", m_en, m_addr); end
    step(); step();
    n_checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h8A00_0001) begin n_fail++; $display("FAIL rstmid_after_ack: got ack=%0b rdata=%h exp 1/8a000001", if_ack, if_rdata); end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_deassert_mid();
    mem_req = 1'b1; mem_rw = 1'b0; mem_addr = 32'h44;
    step(); // grant
    mem_req = 1'b0;
    step();
    step();
    n_checks++; if (mem_ack !== 1'b1 || mem_rdata !== 32'hFFFF_FFBB) begin n_fail++; $display("FAIL deassert_ack: got ack=%0b rdata=%h exp 1/ffffffbb", mem_ack, mem_rdata); end
    step();
    n_checks++; if (mem_ack !== 1'b0 || m_en !== 1'b0) begin n_fail++; $display("FAIL deassert_after: got ack=%0b en=%0b exp 0/0", mem_ack, m_en); end
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_tie_after_reset();
    test_contention();
    test_store();
    test_reset_mid_access();
    test_deassert_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
